// File: rtl/sprite_loader.sv
// Byte-stream loader for the sprite bitmap RAM: parses SYNC/slot/payload packets
// and writes one unpacked pixel per cycle, pausing while hold is high.
module sprite_loader #(
  parameter int SPR_WIDTH  = 8,
  parameter int SPR_HEIGHT = 8,
  parameter int SPR_DATAW  = 1,
  parameter int SPR_SLOTS  = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  localparam int DEPTH = SPR_WIDTH * SPR_HEIGHT,
  localparam int AW    = $clog2(SPR_SLOTS * DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 hold,
  input  logic                 abort,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [SPR_DATAW-1:0] wr_data,
  output logic                 busy,
  output logic                 load_done,
  output logic                 err
);

  localparam int PPB = 8 / SPR_DATAW;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW  = (PPB > 1) ? $clog2(PPB) : 1;
  localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);
  localparam logic [PW-1:0] LAST_PIX = PW'(DEPTH - 1);
  localparam logic [SW-1:0] LAST_SUB = SW'(PPB - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SLOT   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_UNPACK = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           state_reg, state_next;
  logic [AW-1:0]        base_reg, base_next;
  logic [PW-1:0]        pix_reg, pix_next;
  logic [SW-1:0]        sub_reg, sub_next;
  logic [7:0]           shreg_reg, shreg_next;
  logic                 wr_en_reg, wr_en_next;
  logic [AW-1:0]        wr_addr_reg, wr_addr_next;
  logic [SPR_DATAW-1:0] wr_data_reg, wr_data_next;
  logic                 busy_reg;
  logic                 load_done_reg, load_done_next;
  logic                 err_reg, err_next;
  logic                 take;

  assign in_ready = ((state_reg == S_IDLE) || (state_reg == S_SLOT) || (state_reg == S_DATA))
                    && !hold && !abort;
  assign take = in_valid && in_ready;

  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign busy      = busy_reg;
  assign load_done = load_done_reg;
  assign err       = err_reg;

  // Pixel 0 of each byte is written straight from the consuming DATA cycle so
  // that writes stay back-to-back across byte boundaries.
  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    pix_next       = pix_reg;
    sub_next       = sub_reg;
    shreg_next     = shreg_reg;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    load_done_next = 1'b0;
    err_next       = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (take && (in_data == SYNC_BYTE)) state_next = S_SLOT;
        end
        S_SLOT: begin
          if (take) begin
            if (int'(in_data) < SPR_SLOTS) begin
              base_next  = AW'(in_data) * DEPTH_AW;
              pix_next   = '0;
              state_next = S_DATA;
            end else begin
              err_next   = 1'b1;
              state_next = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            wr_en_next   = 1'b1;
            wr_addr_next = base_reg + AW'(pix_reg);
            wr_data_next = in_data[SPR_DATAW-1:0];
            shreg_next   = in_data >> SPR_DATAW;
            sub_next     = SW'(1);
            if (PPB == 1) begin
              if (pix_reg == LAST_PIX) state_next = S_DONE;
              else pix_next = pix_reg + PW'(1);
            end else begin
              pix_next   = pix_reg + PW'(1);
              state_next = S_UNPACK;
            end
          end
        end
        S_UNPACK: begin
          if (!hold) begin
            wr_en_next   = 1'b1;
            wr_addr_next = base_reg + AW'(pix_reg);
            wr_data_next = shreg_reg[SPR_DATAW-1:0];
            shreg_next   = shreg_reg >> SPR_DATAW;
            if (sub_reg == LAST_SUB) begin
              if (pix_reg == LAST_PIX) begin
                state_next = S_DONE;
              end else begin
                pix_next   = pix_reg + PW'(1);
                state_next = S_DATA;
              end
            end else begin
              pix_next = pix_reg + PW'(1);
              sub_next = sub_reg + SW'(1);
            end
          end
        end
        S_DONE: begin
          load_done_next = 1'b1;
          state_next     = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      base_reg      <= '0;
      pix_reg       <= '0;
      sub_reg       <= '0;
      shreg_reg     <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      busy_reg      <= 1'b0;
      load_done_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      pix_reg       <= pix_next;
      sub_reg       <= sub_next;
      shreg_reg     <= shreg_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      busy_reg      <= (state_next != S_IDLE);
      load_done_reg <= load_done_next;
      err_reg       <= err_next;
    end
  end

endmodule
